// File: rtl/bus_decode_dtack_if.sv
// Bus bundle for the programmable address decoder / DTACK generator.
// The CPU/config side uses the master modport, the decoder the slave modport.
interface bus_decode_dtack_if #(
  parameter int NUM_CS = 16,
  parameter int ADDR_W = 24,
  parameter int WAIT_W = 4
);
  localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  // Decode table programming port
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_start;
  logic [ADDR_W-1:0] cfg_end;
  logic [WAIT_W-1:0] cfg_wait;
  logic [1:0]        cfg_rw;

  // CPU bus cycle
  logic [ADDR_W-1:0] cpu_a;
  logic              cpu_as_n;
  logic              cpu_rw;

  // Per-region slave handshake and decoder results
  logic [NUM_CS-1:0] slv_ready;
  logic [NUM_CS-1:0] cs;
  logic              dtack_n;
  logic              berr_n;
  logic [IDX_W-1:0]  hit_idx;

  modport master (
    output cfg_we, cfg_idx, cfg_start, cfg_end, cfg_wait, cfg_rw,
    output cpu_a, cpu_as_n, cpu_rw, slv_ready,
    input  cs, dtack_n, berr_n, hit_idx
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_start, cfg_end, cfg_wait, cfg_rw,
    input  cpu_a, cpu_as_n, cpu_rw, slv_ready,
    output cs, dtack_n, berr_n, hit_idx
  );
endinterface

// File: rtl/bus_decode_dtack.sv
// Programmable chip-select decoder with per-region wait states, DTACK
// generation and a bus-error timeout. Only the low DEC_BITS address bits are
// decoded, so every region mirrors through the upper address space.
module bus_decode_dtack #(
  parameter int NUM_CS   = 16,
  parameter int ADDR_W   = 24,
  parameter int DEC_BITS = 20,
  parameter int WAIT_W   = 4,
  parameter int TIMEOUT  = 255
) (
  input logic                clk,
  input logic                reset_n,
  bus_decode_dtack_if.slave  bus
);
  localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, NOHIT, ACK, ERR} state_t;

  logic [DEC_BITS-1:0] tbl_start [NUM_CS];
  logic [DEC_BITS-1:0] tbl_end   [NUM_CS];
  logic [WAIT_W-1:0]   tbl_wait  [NUM_CS];
  logic [1:0]          tbl_rw    [NUM_CS];

  state_t              state;
  logic [NUM_CS-1:0]   cs_q;
  logic [IDX_W-1:0]    hit_q;
  logic                dtack_q;
  logic                berr_q;
  logic [WAIT_W-1:0]   cnt;
  logic [TMO_W-1:0]    tmo;

  logic [DEC_BITS-1:0] a_dec;
  logic [NUM_CS-1:0]   match;
  logic                hit_any;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_CS-1:0]   win_onehot;

  assign a_dec = bus.cpu_a[DEC_BITS-1:0];

  // Address bits above the decoded window are deliberately ignored (mirroring).
  generate
    if (DEC_BITS < ADDR_W) begin : g_mirror
      logic unused_upper_bits;
      assign unused_upper_bits = ^{bus.cpu_a[ADDR_W-1:DEC_BITS],
                                   bus.cfg_start[ADDR_W-1:DEC_BITS],
                                   bus.cfg_end[ADDR_W-1:DEC_BITS]};
    end
  endgenerate

  // Range and wait fields need no reset: a disabled entry never matches.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_CS)) begin
      tbl_start[bus.cfg_idx] <= bus.cfg_start[DEC_BITS-1:0];
      tbl_end[bus.cfg_idx]   <= bus.cfg_end[DEC_BITS-1:0];
      tbl_wait[bus.cfg_idx]  <= bus.cfg_wait;
    end
  end

  // Access-mode field; reset disables every region.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CS; i++) tbl_rw[i] <= 2'd3;
    end else if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_CS)) begin
      tbl_rw[bus.cfg_idx] <= bus.cfg_rw;
    end
  end

  // Per-entry match: enabled, direction allowed, address inside inclusive range.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      match[i] = (tbl_rw[i] != 2'd3)
              && ((tbl_rw[i] != 2'd1) || bus.cpu_rw)
              && ((tbl_rw[i] != 2'd2) || !bus.cpu_rw)
              && (tbl_start[i] <= a_dec)
              && (a_dec <= tbl_end[i]);
    end
  end

  // Lowest matching index wins, so the chip-select is always one-hot or zero.
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    win_onehot = hit_any ? (NUM_CS'(1) << win_idx) : '0;
  end

  // Bus-cycle sequencer: decode on AS fall, count wait states, ack or time out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cs_q    <= '0;
      hit_q   <= '0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      cnt     <= '0;
      tmo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.cpu_as_n) begin
            tmo <= '0;
            if (hit_any) begin
              cs_q  <= win_onehot;
              hit_q <= win_idx;
              cnt   <= tbl_wait[win_idx];
              state <= WAIT;
            end else begin
              cs_q  <= '0;
              hit_q <= '0;
              cnt   <= '0;
              state <= NOHIT;
            end
          end
        end
        WAIT: begin
          if (bus.cpu_as_n) begin
            state   <= IDLE;
            cs_q    <= '0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
          end else if ((cnt == '0) && bus.slv_ready[hit_q]) begin
            dtack_q <= 1'b0;
            state   <= ACK;
          end else if (tmo == TMO_LAST) begin
            berr_q <= 1'b0;
            cs_q   <= '0;
            state  <= ERR;
          end else begin
            if (cnt != '0) cnt <= cnt - WAIT_W'(1);
            tmo <= tmo + TMO_W'(1);
          end
        end
        NOHIT: begin
          if (bus.cpu_as_n) begin
            state   <= IDLE;
            cs_q    <= '0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
          end else if (tmo == TMO_LAST) begin
            berr_q <= 1'b0;
            cs_q   <= '0;
            state  <= ERR;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ACK, ERR: begin
          if (bus.cpu_as_n) begin
            state   <= IDLE;
            cs_q    <= '0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cs_q    <= '0;
          dtack_q <= 1'b1;
          berr_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cs      = cs_q;
  assign bus.hit_idx = hit_q;
  assign bus.dtack_n = dtack_q;
  assign bus.berr_n  = berr_q;

endmodule

// File: doc/bus_decode_dtack.md
BUS_DECODE_DTACK -- requirements
Module: bus_decode_dtack

Interface
REQ-001 SHALL have parameter NUM_CS, default 16: number of programmable chip-select regions.
REQ-002 SHALL have parameter ADDR_W, default 24: CPU address width.
REQ-003 SHALL have parameter DEC_BITS, default 20: low address bits compared; upper bits ignored, giving mirroring.
REQ-004 SHALL have parameter WAIT_W, default 4: per-region wait-state count width.
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles before bus error.
REQ-006 SHALL have port clk, input, 1: single clock; synchronous, active-low reset reset_n; all logic on rising clk.
REQ-007 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port cfg_we, input, 1: writes table entry cfg_idx.
REQ-009 SHALL have port cfg_idx, input, clog2(NUM_CS): entry index.
REQ-010 SHALL have ports cfg_start and cfg_end, input, ADDR_W each: inclusive range.
REQ-011 SHALL have port cfg_wait, input, WAIT_W: wait states.
REQ-012 SHALL have port cfg_rw, input, 2: 0 any, 1 read-only, 2 write-only, 3 disabled.
REQ-013 SHALL have ports cpu_a (input, ADDR_W), cpu_as_n (input, 1) and cpu_rw (input, 1, 1=read).
REQ-014 SHALL have port slv_ready, input, NUM_CS: per-region ready; tie high when unused.
REQ-015 SHALL have port cs, output, NUM_CS: registered one-hot chip selects.
REQ-016 SHALL have ports dtack_n (output, 1) and berr_n (output, 1), both active low.
REQ-017 SHALL have port hit_idx, output, clog2(NUM_CS): latched winning index.

Function
REQ-018 SHALL match entry i when cfg_rw != 3, start[DEC_BITS-1:0] <= a[DEC_BITS-1:0] <= end[DEC_BITS-1:0], and rw filter passes; start > end never matches.
REQ-019 SHALL resolve multiple matches by lowest index priority; cs is never multi-hot.
REQ-020 SHALL use states IDLE, WAIT, NOHIT, ACK, ERR.
REQ-021 IDLE: on edge k, if cpu_as_n is sampled low, SHALL register cs, hit_idx, cnt=cfg_wait of winner and tmo=0, then go to WAIT; with no match, SHALL go to NOHIT with cs=0.
REQ-022 WAIT: when cnt!=0, SHALL decrement cnt; when cnt==0 and slv_ready[hit_idx], SHALL go to ACK with dtack_n<=0; dtack_n therefore falls at edge k+1+wait at the earliest.
REQ-023 WAIT and NOHIT: SHALL increment tmo each cycle; when tmo reaches TIMEOUT-1 (slave still not ready, or no hit), SHALL go to ERR with berr_n<=0 and cs<=0.
REQ-024 ACK and ERR: SHALL hold outputs until cpu_as_n is sampled high.
REQ-025 Any non-IDLE state with cpu_as_n sampled high (completion or abort) SHALL go to IDLE on that edge with cs=0, dtack_n=1, berr_n=1; a new cycle SHALL NOT start on the same edge.
REQ-026 cfg_we SHALL update the entry on the next edge; an in-flight cycle SHALL keep its latched cs, hit_idx and cnt.
REQ-027 A cfg write and an AS fall on the same edge SHALL decode with the old table contents.
REQ-028 cpu_a and cpu_rw changes after edge k SHALL NOT alter cs for the current cycle.
REQ-029 Counter widths SHALL be WAIT_W for cnt and clog2(TIMEOUT+1) for tmo; neither wraps.

Reset
REQ-030 reset_n low at an edge SHALL force: state IDLE, cs=0, hit_idx=0, dtack_n=1, berr_n=1, cnt=0, tmo=0, all entries cfg_rw=3 (disabled), regardless of any cycle in progress.
REQ-031 After reset release, the first decode SHALL require cpu_as_n sampled low in IDLE.

Verification
REQ-032 Entry 0 = 0x000000-0x07FFFF, wait 0; read at 0x012340 -> cs=0x0001 at edge k, dtack_n low at edge k+1; AS high -> all cleared next edge.
REQ-033 Entry 2 = 0x0F0000-0x0FFFFF, wait 3; access 0x1F8000 (mirror) -> cs[2] set, dtack_n low at edge k+4.
REQ-034 Entries 1 and 5 overlap at 0x080002; entry 1 read-only; write -> cs[5]; read -> cs[1].
REQ-035 Unmapped 0x0A0000 with TIMEOUT=255 -> cs=0, berr_n low 255 cycles after entry to NOHIT; slv_ready held low in WAIT -> same berr_n timing, cs cleared.
REQ-036 reset_n low while in WAIT with cnt=2 -> next edge all outputs at reset values and table disabled; subsequent access -> NOHIT.
REQ-037 Abort: AS high while in WAIT -> IDLE, dtack_n never asserted.
